// File: rtl/xbar_cfg_loader.sv
// Streams config words into a shadow image, range-checks every select field,
// then commits atomically to the crossbar's active mux configuration.
// Optional readback port: define XBAR_CFG_READBACK_EN.
module xbar_cfg_loader #(
  parameter  int NUM_INS   = 34,
  parameter  int NUM_OUTS  = 45,
  parameter  int SEL_W     = 6,
  parameter  int WORD_W    = 32,
  localparam int CFG_W     = NUM_OUTS * SEL_W,
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_cfg_start,
  input  logic              io_cfg_valid,
  output logic              io_cfg_ready,
  input  logic [WORD_W-1:0] io_cfg_data,
  output logic              io_busy,
  output logic              io_cfg_done,
  output logic              io_cfg_err,
  output logic [5:0]        io_err_field,
  output logic [CFG_W-1:0]  io_mux_configs
`ifdef XBAR_CFG_READBACK_EN
  ,
  input  logic [3:0]        io_rb_addr,
  output logic [WORD_W-1:0] io_rb_data
`endif
);

  // state  | meaning
  // IDLE   | waiting for io_cfg_start
  // LOAD   | accepting words into the shadow image
  // CHECK  | range-checking every select field of the shadow
  // COMMIT | copy shadow to active if legal, pulse done or err

  localparam int                IDX_W       = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_WORDS - 1);
  localparam logic [SEL_W-1:0]  NUM_INS_SEL = SEL_W'(NUM_INS);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CFG_W-1:0] shadow;
  logic             chk_fail;
  logic             any_bad;
  logic [5:0]       bad_idx;

  assign io_cfg_ready = (state == LOAD);

  // Scan from the top so the lowest illegal index wins.
  always_comb begin
    any_bad = 1'b0;
    bad_idx = '0;
    for (int i = NUM_OUTS - 1; i >= 0; i--) begin
      if (shadow[i*SEL_W +: SEL_W] >= NUM_INS_SEL) begin
        any_bad = 1'b1;
        bad_idx = 6'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      shadow         <= '0;
      io_mux_configs <= '0;
      io_busy        <= 1'b0;
      io_cfg_done    <= 1'b0;
      io_cfg_err     <= 1'b0;
      io_err_field   <= '0;
      chk_fail       <= 1'b0;
    end else begin
      io_cfg_done <= 1'b0;
      io_cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (io_cfg_start) begin
            state   <= LOAD;
            idx     <= '0;
            io_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (io_cfg_start) begin
            idx <= '0;
          end else if (io_cfg_valid) begin
            // Bits of the last word beyond CFG_W have no home and are dropped.
            for (int i = 0; i < CFG_W; i++) begin
              if (idx == IDX_W'(i / WORD_W))
                shadow[i] <= io_cfg_data[i % WORD_W];
            end
            if (idx == LAST_IDX) state <= CHECK;
            else                 idx   <= idx + 1'b1;
          end
        end
        CHECK: begin
          chk_fail <= any_bad;
          if (any_bad) io_err_field <= bad_idx;
          state <= COMMIT;
        end
        COMMIT: begin
          if (!chk_fail) begin
            io_mux_configs <= shadow;
            io_cfg_done    <= 1'b1;
          end else begin
            io_cfg_err <= 1'b1;
          end
          io_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XBAR_CFG_READBACK_EN
  logic [WORD_W-1:0] rb_next;

  always_comb begin
    rb_next = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (io_rb_addr == 4'(w)) begin
        for (int b = 0; b < WORD_W; b++) begin
          if (w * WORD_W + b < CFG_W) rb_next[b] = io_mux_configs[w*WORD_W + b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) io_rb_data <= '0;
    else        io_rb_data <= rb_next;
  end
`endif

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Randomized self-checking bench for xbar_cfg_loader against a packed-image
// reference model; readback checks are included when XBAR_CFG_READBACK_EN is set.
module tb_xbar_cfg_loader;
  localparam int NI = 34, NO = 45, SW = 6, WW = 32, CW = 270, NW = 9;

  typedef logic [WW-1:0] word_arr_t [NW];

  logic          clk = 1'b0;
  logic          reset;
  logic          io_cfg_start, io_cfg_valid, io_cfg_ready;
  logic [WW-1:0] io_cfg_data;
  logic          io_busy, io_cfg_done, io_cfg_err;
  logic [5:0]    io_err_field;
  logic [CW-1:0] io_mux_configs;
`ifdef XBAR_CFG_READBACK_EN
  logic [3:0]    io_rb_addr;
  logic [WW-1:0] io_rb_data;
`endif

  always #5 clk = ~clk;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_start   (io_cfg_start),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_data    (io_cfg_data),
    .io_busy        (io_busy),
    .io_cfg_done    (io_cfg_done),
    .io_cfg_err     (io_cfg_err),
    .io_err_field   (io_err_field),
    .io_mux_configs (io_mux_configs)
`ifdef XBAR_CFG_READBACK_EN
    ,
    .io_rb_addr     (io_rb_addr),
    .io_rb_data     (io_rb_data)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [CW-1:0] m_active;
  logic [5:0]    m_err_field;
  int            m_done_cnt, m_err_cnt;
  int            seen_done = 0, seen_err = 0;

  always @(negedge clk) begin
    if (io_cfg_done) seen_done++;
    if (io_cfg_err)  seen_err++;
  end

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Field values: pattern i%34 or random legal; one field optionally forced; junk above CFG_W.
  task automatic make_words(input int bad_field, input int bad_val, input bit pattern,
                            output word_arr_t w);
    logic [287:0] img;
    int f;
    img = '0;
    for (int i = 0; i < NO; i++) begin
      f = pattern ? (i % NI) : int'($urandom_range(0, NI - 1));
      if (i == bad_field) f = bad_val;
      img[i*SW +: SW] = 6'(f);
    end
    img[287:CW] = 18'($urandom);
    for (int k = 0; k < NW; k++) w[k] = img[k*WW +: WW];
  endtask

  task automatic run_load(input word_arr_t w, input int gap_mode, input bit restart);
    logic [287:0] img;
    logic [5:0]   bad;
    bit           ok;
    int           gaps;
    for (int k = 0; k < NW; k++) img[k*WW +: WW] = w[k];
    ok = 1'b1;
    bad = '0;
    for (int i = 0; i < NO; i++) begin
      if (ok && (((img >> (i * SW)) & 288'h3f) >= NI)) begin
        ok  = 1'b0;
        bad = 6'(i);
      end
    end

    io_cfg_start = 1'b1;
    step();
    io_cfg_start = 1'b0;
    chk("ready_in_load", io_cfg_ready, 1'b1);
    chk("busy_in_load", io_busy, 1'b1);

    if (restart) begin
      for (int k = 0; k < 4; k++) begin
        io_cfg_valid = 1'b1;
        io_cfg_data  = $urandom;
        step();
      end
      io_cfg_start = 1'b1;
      io_cfg_data  = $urandom;
      step();
      io_cfg_start = 1'b0;
      chk("ready_after_restart", io_cfg_ready, 1'b1);
    end

    for (int k = 0; k < NW; k++) begin
      gaps = 0;
      if (k > 0 && gap_mode == 1) gaps = 2;
      if (gap_mode == 2) gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        io_cfg_valid = 1'b0;
        io_cfg_data  = $urandom;
        step();
        chk("ready_in_gap", io_cfg_ready, 1'b1);
      end
      io_cfg_valid = 1'b1;
      io_cfg_data  = w[k];
      step();
    end
    io_cfg_valid = 1'b0;
    io_cfg_data  = $urandom;

    chk("ready_in_check", io_cfg_ready, 1'b0);
    chk("busy_in_check", io_busy, 1'b1);
    step();
    chk("done_not_early", io_cfg_done, 1'b0);
    chk("mux_hold_before_commit", io_mux_configs, m_active);
    step();
    if (ok) begin
      m_active = img[CW-1:0];
      m_done_cnt++;
    end else begin
      m_err_field = bad;
      m_err_cnt++;
    end
    chk("done_pulse", io_cfg_done, ok);
    chk("err_pulse", io_cfg_err, !ok);
    chk("err_field", io_err_field, m_err_field);
    chk("mux_after_commit", io_mux_configs, m_active);
    chk("busy_after_commit", io_busy, 1'b0);
    step();
    chk("done_one_cycle", io_cfg_done, 1'b0);
    chk("err_one_cycle", io_cfg_err, 1'b0);
  endtask

  word_arr_t w;
  int        bf;

  initial begin
    reset        = 1'b0;
    io_cfg_start = 1'b0;
    io_cfg_valid = 1'b0;
    io_cfg_data  = '0;
`ifdef XBAR_CFG_READBACK_EN
    io_rb_addr   = '0;
`endif
    m_active    = '0;
    m_err_field = '0;
    m_done_cnt  = 0;
    m_err_cnt   = 0;
    step();
    step();
    chk("rst_mux", io_mux_configs, '0);
    chk("rst_ready", io_cfg_ready, 1'b0);
    chk("rst_busy", io_busy, 1'b0);
    chk("rst_done", io_cfg_done, 1'b0);
    chk("rst_err", io_cfg_err, 1'b0);
    chk("rst_err_field", io_err_field, '0);
`ifdef XBAR_CFG_READBACK_EN
    chk("rst_rb_data", io_rb_data, '0);
`endif
    reset = 1'b1;
    step();

    // Valid without start is ignored in IDLE.
    io_cfg_valid = 1'b1;
    io_cfg_data  = $urandom;
    step();
    io_cfg_valid = 1'b0;
    chk("idle_ignores_valid", io_cfg_ready, 1'b0);

    make_words(-1, 0, 1'b1, w);
    run_load(w, 0, 1'b0);
    chk("clean_field2", io_mux_configs[17:12], 6'd2);
    chk("clean_field44", io_mux_configs[269:264], 6'd10);
`ifdef XBAR_CFG_READBACK_EN
    io_rb_addr = 4'd8;
    step();
    chk("rb_word8", io_rb_data, {18'b0, w[8][13:0]});
    io_rb_addr = 4'd12;
    step();
    chk("rb_addr12", io_rb_data, '0);
    for (int k = 0; k < 6; k++) begin
      io_rb_addr = 4'($urandom_range(0, 15));
      step();
      chk("rb_random", io_rb_data,
          (io_rb_addr < NW) ? ({18'b0, m_active} >> (io_rb_addr * WW)) & 288'hffffffff : 288'h0);
    end
`endif

    make_words(3, 40, 1'b1, w);
    run_load(w, 0, 1'b0);

    make_words(-1, 0, 1'b0, w);
    run_load(w, 1, 1'b0);

    make_words(-1, 0, 1'b0, w);
    run_load(w, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      bf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NO - 1)) : -1;
      make_words(bf, int'($urandom_range(NI, 63)), 1'b0, w);
      run_load(w, int'($urandom_range(0, 2)), $urandom_range(0, 4) == 0);
    end

    // Reset in the middle of a load clears everything.
    io_cfg_start = 1'b1;
    step();
    io_cfg_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = $urandom;
      step();
    end
    io_cfg_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_active    = '0;
    m_err_field = '0;
    chk("midrst_mux", io_mux_configs, '0);
    chk("midrst_busy", io_busy, 1'b0);
    chk("midrst_ready", io_cfg_ready, 1'b0);
    chk("midrst_err_field", io_err_field, '0);
    step();

    make_words(-1, 0, 1'b0, w);
    run_load(w, 2, 1'b0);

    step();
    chk("done_pulse_count", seen_done, m_done_cnt);
    chk("err_pulse_count", seen_err, m_err_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/xbar_cfg_loader.md
Name: xbar_cfg_loader

Overview:
- Write-side companion to the LUT-tile crossbar.
- Accepts configuration words over a valid/ready stream and assembles them into a shadow register.
- Range-checks every select field, then atomically commits the image to the active register that drives the crossbar's mux_configs input.
- The crossbar therefore never sees a partially loaded or illegal configuration.

Parameters:
- NUM_INS, 34, crossbar input count; legal select values are 0..NUM_INS-1.
- NUM_OUTS, 45, crossbar output count (number of select fields).
- SEL_W, 6, bits per select field.
- WORD_W, 32, config stream word width.
- CFG_W (derived), NUM_OUTS*SEL_W = 270, total config bits.
- NUM_WORDS (derived), ceil(CFG_W/WORD_W) = 9, words per load.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-low
- io_cfg_start  input  1  begin a new load (single-cycle pulse)
- io_cfg_valid  input  1  io_cfg_data is valid
- io_cfg_ready  output  1  loader accepts a word this cycle
- io_cfg_data  input  WORD_W  config word, field 0 in LSBs of word 0
- io_busy  output  1  load or check in progress
- io_cfg_done  output  1  one-cycle pulse: commit succeeded
- io_cfg_err  output  1  one-cycle pulse: commit rejected
- io_err_field  output  6  lowest-index illegal field of the last rejected load
- io_mux_configs  output  CFG_W  active configuration, to crossbar

Behaviour:
- Reset (reset==0 at posedge):
  - State = IDLE.
  - Shadow and active registers = 0, so io_mux_configs = 0 (all outputs select input 0).
  - io_cfg_ready, io_busy, io_cfg_done, io_cfg_err = 0; io_err_field = 0.
  - Reset mid-load aborts the load; the active register is cleared to 0.
- FSM states are IDLE, LOAD, CHECK, COMMIT. All outputs are registered except io_cfg_ready, which is 1 exactly when state==LOAD.
- IDLE:
  - io_cfg_start=1 -> LOAD, word index = 0.
  - io_cfg_valid is ignored in IDLE.
- LOAD:
  - A word is accepted on each cycle with valid & ready.
  - Each accepted word is written to shadow[idx*WORD_W +: WORD_W].
  - Bits at or above CFG_W are discarded; word 8 uses only bits [13:0].
  - idx increments per accepted word. Acceptance of word NUM_WORDS-1 -> CHECK.
  - Gaps in valid are allowed and have no timeout.
  - io_cfg_start in LOAD restarts the load: idx = 0, no word accepted that cycle, shadow contents retained but will be overwritten.
- CHECK (one cycle):
  - Every field shadow[i*SEL_W +: SEL_W] is compared against NUM_INS.
  - Any field >= NUM_INS marks an error; io_err_field is captured with the lowest such i.
  - Next state is COMMIT.
- COMMIT (one cycle):
  - No error: active <= shadow, io_cfg_done=1 for the following cycle.
  - Error: active unchanged, io_cfg_err=1 for the following cycle.
  - Next state is IDLE. io_cfg_start in CHECK or COMMIT is ignored.
- Latency: last word accepted at edge E; the check completes at E+1; io_mux_configs updates and io_cfg_done rises at edge E+2.
- io_busy is 1 in LOAD, CHECK and COMMIT.
- io_mux_configs changes only at a successful commit or at reset; never partially.

Optional Feature:
- Macro XBAR_CFG_READBACK_EN.
- When defined:
  - Adds io_rb_addr input 4 bits and io_rb_data output WORD_W bits.
  - io_rb_data is registered: one cycle after io_rb_addr is presented it holds active[addr*WORD_W +: WORD_W], zero-padded above CFG_W.
  - addr >= NUM_WORDS returns 0.
  - Reset value of io_rb_data is 0.
  - Readback is allowed in any state.
- When undefined: these ports are absent and no readback logic is built.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> io_mux_configs=0, io_cfg_ready=0, io_busy=0, io_cfg_done=0, io_cfg_err=0.
- Clean load: start, then 9 back-to-back words encoding field i = i mod 34 -> io_cfg_done pulses 2 cycles after the 9th accept; io_mux_configs[17:12]=2 and io_mux_configs[269:264]=10.
- Illegal select: same load but field 3 = 40 (word 0 bits [23:18]) -> io_cfg_err pulses, io_err_field=3, io_mux_configs keeps the previous value.
- Backpressure/gaps: valid toggled 1-0-0-1 pattern across 9 words -> exactly 9 words captured, io_cfg_ready=1 throughout LOAD, then correct commit.
- Restart: start, 4 words, start again, 9 new words -> committed image equals the 9 new words only; exactly one io_cfg_done.
- Readback (XBAR_CFG_READBACK_EN): after the clean load, io_rb_addr=8 -> io_rb_data[13:0] equals word 8 bits [13:0] and bits [31:14]=0 next cycle; io_rb_addr=12 -> io_rb_data=0.
